dmem_access_ctrl: RTL

Data-memory access controller for the MEM stage of the RV32I pipeline. It turns the M-stage load/store into a req/ack transaction on a variable-latency data bus. While the access is in flight it freezes the pipeline. It then presents an aligned, sign/zero-extended load result plus load-valid and error flags to the MEM/WB pipeline register. Misaligned, illegal-size and timed-out accesses are reported as flags rather than stalling forever.

---
 rtl/rv32i_pkg.sv | 26 ++
 rtl/lsu_align.sv | 66 ++++++
 rtl/dmem_access_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions for the MEM-stage data access path.
// Holds the load/store size encodings and the access controller state type.
package rv32i_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } dmemState_t;

    // Unsigned sizes only exist for loads.
    function automatic logic isSizeLegal(input logic [2:0] funct3, input logic isStore);
        case (funct3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return !isStore;
            default:          return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane logic: legality/alignment of the request, store strobes
// and replication, and extraction plus extension of the returned load word.
module lsu_align
    import rv32i_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addrLo,
    input  logic        isLoad,
    input  logic        isStore,
    input  logic [31:0] storeData,
    input  logic [2:0]  ldFunct3,
    input  logic [1:0]  ldAddrLo,
    input  logic [31:0] rdata,
    output logic        accessOk,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] loadData
);

    logic        legal;
    logic        aligned;
    logic [7:0]  ldByte;
    logic [15:0] ldHalf;

    always_comb begin
        legal   = isSizeLegal(funct3, isStore) && !(isLoad && isStore);
        aligned = 1'b1;
        case (funct3)
            F3_H, F3_HU: aligned = !addrLo[0];
            F3_W:        aligned = (addrLo == 2'b00);
            default:     aligned = 1'b1;
        endcase
        accessOk = legal && aligned;
    end

    always_comb begin
        wstrb = 4'b0000;
        wdata = storeData;
        case (funct3)
            F3_B: begin
                wstrb = 4'b0001 << addrLo;
                wdata = {4{storeData[7:0]}};
            end
            F3_H: begin
                wstrb = 4'b0011 << addrLo;
                wdata = {2{storeData[15:0]}};
            end
            F3_W:    wstrb = 4'b1111;
            default: wstrb = 4'b0000;
        endcase
    end

    always_comb begin
        ldByte   = rdata[{ldAddrLo, 3'b000} +: 8];
        ldHalf   = ldAddrLo[1] ? rdata[31:16] : rdata[15:0];
        loadData = rdata;
        case (ldFunct3)
            F3_B:    loadData = {{24{ldByte[7]}}, ldByte};
            F3_BU:   loadData = {24'b0, ldByte};
            F3_H:    loadData = {{16{ldHalf[15]}}, ldHalf};
            F3_HU:   loadData = {16'b0, ldHalf};
            default: loadData = rdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// MEM-stage data access controller: turns the M-stage load/store into a req/ack bus
// transaction, stalls the pipeline while it is in flight and flags bad accesses.
//
// state | meaning
// IDLE  | no access in flight; a new M-stage access is detected here
// REQ   | mem_req held, waiting for mem_ack or the timeout down-counter to expire
// DONE  | result/flags presented for one cycle while the instruction leaves M
module dmem_access_ctrl
    import rv32i_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [2:0]  Funct3M,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] ReadDataM,
    output logic        LoadValidM,
    output logic        StallM,
    output logic        MisalignM,
    output logic        BusErrM
);

    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);

    dmemState_t  state;
    dmemState_t  nextState;
    logic [TW-1:0] timer;
    logic        timerDone;
    logic        accessReq;
    logic        accessOk;
    logic [2:0]  reqFunct3;
    logic [1:0]  reqAddrLo;
    logic        reqIsLoad;
    logic        misalignFlag;
    logic        busErrFlag;
    logic        loadOkFlag;
    logic [3:0]  alignWstrb;
    logic [31:0] alignWdata;
    logic [31:0] alignLoad;

    assign accessReq = MemReadM || MemWriteM;
    assign timerDone = (timer == '0);

    lsu_align uAlign (
        .funct3    (Funct3M),
        .addrLo    (ALUResultM[1:0]),
        .isLoad    (MemReadM),
        .isStore   (MemWriteM),
        .storeData (WriteDataM),
        .ldFunct3  (reqFunct3),
        .ldAddrLo  (reqAddrLo),
        .rdata     (mem_rdata),
        .accessOk  (accessOk),
        .wstrb     (alignWstrb),
        .wdata     (alignWdata),
        .loadData  (alignLoad)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accessReq) begin
                    nextState = accessOk ? REQ : DONE;
                end
            end
            REQ: begin
                if (mem_ack || timerDone) begin
                    nextState = DONE;
                end
            end
            DONE:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    // Bus outputs, timeout counter, captured load data and the DONE-cycle flags.
    always_ff @(posedge clk) begin
        if (!reset) begin
            timer        <= '0;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_wstrb    <= '0;
            ReadDataM    <= '0;
            reqFunct3    <= '0;
            reqAddrLo    <= '0;
            reqIsLoad    <= 1'b0;
            misalignFlag <= 1'b0;
            busErrFlag   <= 1'b0;
            loadOkFlag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accessReq && accessOk) begin
                        mem_req   <= 1'b1;
                        mem_we    <= MemWriteM;
                        mem_addr  <= {ALUResultM[31:2], 2'b00};
                        mem_wdata <= MemWriteM ? alignWdata : '0;
                        mem_wstrb <= MemWriteM ? alignWstrb : '0;
                        reqFunct3 <= Funct3M;
                        reqAddrLo <= ALUResultM[1:0];
                        reqIsLoad <= MemReadM;
                        timer     <= TIMER_LOAD;
                    end else if (accessReq) begin
                        misalignFlag <= 1'b1;
                        ReadDataM    <= '0;
                    end
                end
                REQ: begin
                    if (mem_ack || timerDone) begin
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        mem_wstrb <= '0;
                        timer     <= '0;
                        // An ack in the final counted cycle still completes normally.
                        if (mem_ack) begin
                            if (reqIsLoad) begin
                                ReadDataM  <= alignLoad;
                                loadOkFlag <= 1'b1;
                            end
                        end else begin
                            busErrFlag <= 1'b1;
                            ReadDataM  <= '0;
                        end
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                DONE: begin
                    misalignFlag <= 1'b0;
                    busErrFlag   <= 1'b0;
                    loadOkFlag   <= 1'b0;
                end
                default: begin
                    misalignFlag <= 1'b0;
                    busErrFlag   <= 1'b0;
                    loadOkFlag   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        StallM     = 1'b0;
        LoadValidM = 1'b0;
        MisalignM  = 1'b0;
        BusErrM    = 1'b0;
        if (reset) begin
            StallM     = ((state == IDLE) && accessReq) || (state == REQ);
            LoadValidM = (state == DONE) && loadOkFlag;
            MisalignM  = (state == DONE) && misalignFlag;
            BusErrM    = (state == DONE) && busErrFlag;
        end
    end

endmodule
